// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if: operand/result handshake bundle for the pipelined CLA adder/subtractor
interface cla_pipe_addsub_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: two-stage 32-bit two-level carry-lookahead adder/subtractor with valid/ready on both sides
module cla_pipe_addsub (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_addsub_if.slave bus
);
    function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        cla4[0] = g[0] | (p[0] & ci);
        cla4[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        cla4[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        cla4[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    endfunction
    function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
        gen4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction
    logic        s1_valid, s2_valid, s1_load, s2_load, cin_r;
    logic [31:0] b_eff, g, p, g_r, p_r;
    logic [7:0]  gg, pp, gg_r, pp_r;
    logic [3:0]  gc_lo, gc_hi;
    logic [8:0]  gc;
    logic [32:0] c;
    always_comb begin
        b_eff = bus.b ^ {32{bus.sub}};
        g = bus.a & b_eff;
        p = bus.a ^ b_eff;
        for (int k = 0; k < 8; k++) begin
            gg[k] = gen4(g[4*k +: 4], p[4*k +: 4]);
            pp[k] = &p[4*k +: 4];
        end
    end
    // group carries: two lookahead levels, upper half seeded from C[4]
    assign gc_lo = cla4(gg_r[3:0], pp_r[3:0], cin_r);
    assign gc_hi = cla4(gg_r[7:4], pp_r[7:4], gc_lo[3]);
    assign gc    = {gc_hi, gc_lo, cin_r};
    always_comb begin
        c[0] = cin_r;
        for (int k = 0; k < 8; k++)
            c[4*k+1 +: 4] = cla4(g_r[4*k +: 4], p_r[4*k +: 4], gc[k]);
    end
    assign s2_load       = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready  = !s1_valid || s2_load;
    assign s1_load       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            g_r      <= '0;
            p_r      <= '0;
            gg_r     <= '0;
            pp_r     <= '0;
            cin_r    <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
        end else begin
            if (s1_load || s2_load)
                s1_valid <= s1_load;
            if (s2_load || bus.out_ready)
                s2_valid <= s2_load;
            if (s1_load) begin
                g_r   <= g;
                p_r   <= p;
                gg_r  <= gg;
                pp_r  <= pp;
                cin_r <= bus.sub;
            end
            if (s2_load) begin
                bus.sum  <= p_r ^ c[31:0];
                bus.cout <= c[32];
                bus.ovf  <= c[32] ^ c[31];
                bus.zero <= ~|(p_r ^ c[31:0]);
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: directed and randomized checks of the pipelined CLA adder/subtractor
module tb_cla_pipe_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [34:0] q[$];
    cla_pipe_addsub_if bus();
    cla_pipe_addsub dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] be;
        logic [32:0] r;
        be = b ^ {32{s}};
        r  = {1'b0, a} + {1'b0, be} + {32'd0, s};
        return {r[32], (a[31] == be[31]) && (r[31] != a[31]), r[31:0] == 32'd0, r[31:0]};
    endfunction

    function automatic logic [63:0] res();
        return {29'd0, bus.cout, bus.ovf, bus.zero, bus.sum};
    endfunction

    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] es, input logic ec, input logic ev, input logic ez);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = s; bus.out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk(tag, res(), {29'd0, ec, ev, ez, es});
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outputs", res(), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        beat("ffff_plus_1",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        beat("maxpos_plus1", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        beat("minneg_sub1",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        beat("5_minus_7",    32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        beat("9_minus_9",    32'd9,        32'd9,        1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        beat("mixed_add",    32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0);
        beat("neg_ovf",      32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
        beat("0_minus_1",    32'd0,        32'd1,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        // stall: three back-to-back beats against a blocked consumer
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.a = 32'h1; bus.b = 32'h2; bus.sub = 1'b0;
        #1 chk("stall_acc1", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.a = 32'h10; bus.b = 32'h20;
        #1 chk("stall_acc2", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.a = 32'h100; bus.b = 32'h1; bus.sub = 1'b1;
        #1 chk("stall_full", 64'(bus.in_ready), 64'd0);
        chk("stall_first", res(), {29'd0, 3'b000, 32'h3});
        repeat (2) @(negedge clk);
        chk("stall_hold_rdy", 64'(bus.in_ready), 64'd0);
        chk("stall_hold", res(), {29'd0, 3'b000, 32'h3});
        bus.out_ready = 1'b1;
        #1 chk("stall_release_rdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stall_second_v", 64'(bus.out_valid), 64'd1);
        chk("stall_second", res(), {29'd0, 3'b000, 32'h30});
        @(negedge clk);
        chk("stall_third_v", 64'(bus.out_valid), 64'd1);
        chk("stall_third", res(), {29'd0, 3'b100, 32'hFF});
        @(negedge clk);
        chk("stall_drained", 64'(bus.out_valid), 64'd0);

        // reset with both stages occupied
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.a = 32'h5; bus.b = 32'h6; bus.sub = 1'b0;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("prerst_full", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_outputs", res(), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst_no_ghost", 64'(bus.out_valid), 64'd0);
        beat("postrst_beat", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // random traffic against a scoreboard
        begin
            int sent = 0;
            int cyc  = 0;
            while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                bus.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
                bus.a         = $urandom;
                bus.b         = ($urandom_range(0, 7) == 0) ? bus.a : $urandom;
                bus.sub       = 1'($urandom_range(0, 1));
                bus.out_ready = $urandom_range(0, 3) != 0;
                #1;
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) chk("rnd_extra", 64'(bus.out_valid), 64'd0);
                    else chk("rnd", res(), {29'd0, q.pop_front()});
                end
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back(model(bus.a, bus.b, bus.sub));
                    sent++;
                end
            end
            bus.in_valid = 1'b0;
            chk("rnd_complete", 64'((10000 - sent) + q.size()), 64'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
